// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration in IDLE, then a standard
// SETUP/ACCESS transfer with a bounded wait for pready. Completion is reported
// as a one-cycle one-hot done pulse, qualified by err for timeouts and
// illegal slave selects.
module apb_master_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        pclk,
    input  logic        Reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic        req0_write,
    input  logic        req1_write,
    input  logic [1:0]  req0_sel,
    input  logic [1:0]  req1_sel,
    input  logic [4:0]  req0_addr,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req0_wdata,
    input  logic [31:0] req1_wdata,
    output logic [1:0]  done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [1:0]  psel,
    output logic        penable,
    output logic        pwrite,
    output logic [4:0]  paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // The edge on which the counter would reach TIMEOUT ends the transfer,
    // so a stuck slave sees exactly TIMEOUT ACCESS cycles.
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t         state;
    state_t         state_next;

    logic           prio1;      // 1: requester 1 wins the next tie
    logic           grant_q;    // requester owning the current transfer
    logic           wr_q;
    logic [1:0]     sel_q;
    logic [4:0]     addr_q;
    logic [31:0]    wdata_q;
    logic [CW-1:0]  wait_cnt;

    logic           pick;
    logic           pick_write;
    logic [1:0]     pick_sel;
    logic [4:0]     pick_addr;
    logic [31:0]    pick_wdata;
    logic           start;
    logic           reject;
    logic           finish_ok;
    logic           finish_to;

    // Arbitration choice, next-state and transfer event decode.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        reject     = 1'b0;
        finish_ok  = 1'b0;
        finish_to  = 1'b0;
        pick       = (req0_valid && req1_valid) ? prio1 : req1_valid;
        pick_write = pick ? req1_write : req0_write;
        pick_sel   = pick ? req1_sel   : req0_sel;
        pick_addr  = pick ? req1_addr  : req0_addr;
        pick_wdata = pick ? req1_wdata : req0_wdata;
        case (state)
            IDLE: begin
                // Valid is ignored while the previous done pulse is showing.
                if ((req0_valid || req1_valid) && (done == 2'b00)) begin
                    if ((pick_sel == 2'b01) || (pick_sel == 2'b10)) begin
                        start      = 1'b1;
                        state_next = SETUP;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    finish_ok  = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == LAST_WAIT) begin
                    finish_to  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge pclk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Round-robin pointer, grant owner and latched request fields.
    always_ff @(posedge pclk) begin
        if (!Reset) begin
            prio1   <= 1'b0;
            grant_q <= 1'b0;
            wr_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (start || reject) begin
                grant_q <= pick;
                prio1   <= ~pick;
            end
            if (start) begin
                wr_q    <= pick_write;
                sel_q   <= pick_sel;
                addr_q  <= pick_addr;
                wdata_q <= pick_wdata;
            end
        end
    end

    // Wait counter: cleared while in SETUP, counts ACCESS cycles with pready low.
    always_ff @(posedge pclk) begin
        if (!Reset) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Completion pulse, error qualifier and read data capture.
    always_ff @(posedge pclk) begin
        if (!Reset) begin
            done  <= '0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            if (reject) begin
                done <= {pick, ~pick};
                err  <= 1'b1;
            end else if (finish_ok) begin
                done <= {grant_q, ~grant_q};
                if (!wr_q) begin
                    rdata <= prdata;
                end
            end else if (finish_to) begin
                done <= {grant_q, ~grant_q};
                err  <= 1'b1;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign psel    = (state != IDLE) ? sel_q : '0;
    assign penable = (state == ACCESS);
    assign pwrite  = wr_q;
    assign paddr   = addr_q;
    assign pwdata  = wdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: the stimulus process predicts each
// transaction's outcome in grant order and queues it; a monitor pops and
// compares on every done pulse; a slave model supplies pready/prdata.
module tb_apb_master_arbiter;

    localparam int TO = 15;

    typedef struct {
        bit           req;
        bit           wr;
        bit [1:0]     sel;
        bit [4:0]     addr;
        bit [31:0]    wdata;
        bit [31:0]    prdata;
        int unsigned  lat;
        bit           legal;
        bit           exp_err;
        int unsigned  exp_acc;
        bit [31:0]    exp_rdata;
    } txn_t;

    logic        pclk = 1'b0;
    logic        Reset;
    logic        req0_valid, req1_valid, req0_write, req1_write;
    logic [1:0]  req0_sel, req1_sel;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_wdata, req1_wdata;
    logic [1:0]  done;
    logic [31:0] rdata;
    logic        err, busy;
    logic [1:0]  psel;
    logic        penable, pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    int checks = 0;
    int failures = 0;

    txn_t exp_q[$];
    bit        prio_m = 1'b0;
    bit [31:0] model_rdata = 32'h0;

    apb_master_arbiter #(.TIMEOUT(TO)) dut (
        .pclk(pclk), .Reset(Reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_write(req0_write), .req1_write(req1_write),
        .req0_sel(req0_sel), .req1_sel(req1_sel),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .done(done), .rdata(rdata), .err(err), .busy(busy),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psel"}, 32'(psel), 0);
        chk({tag, "_penable"}, 32'(penable), 0);
        chk({tag, "_pwrite"}, 32'(pwrite), 0);
        chk({tag, "_paddr"}, 32'(paddr), 0);
        chk({tag, "_pwdata"}, pwdata, 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    function automatic txn_t mk(bit w, bit [1:0] s, bit [4:0] a, bit [31:0] wd,
                                bit [31:0] pd, int unsigned l);
        txn_t t;
        t.req = 1'b0; t.wr = w; t.sel = s; t.addr = a; t.wdata = wd;
        t.prdata = pd; t.lat = l; t.legal = 1'b0; t.exp_err = 1'b0;
        t.exp_acc = 0; t.exp_rdata = 32'h0;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        int unsigned r;
        bit [1:0] s;
        int unsigned l;
        r = $urandom_range(0, 7);
        s = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
        r = $urandom_range(0, 9);
        l = (r < 7) ? (r % 5) : (r == 7) ? (TO - 1) : 20;
        return mk($urandom_range(0, 1) == 1, s, 5'($urandom), $urandom, $urandom, l);
    endfunction

    // Transaction-level outcome: illegal select fails at once, a slave slower
    // than TO cycles times out, a completed read updates the visible rdata.
    function automatic txn_t predict(input txn_t t);
        t.legal   = (t.sel == 2'b01) || (t.sel == 2'b10);
        t.exp_err = !t.legal || (t.lat >= TO);
        t.exp_acc = !t.legal ? 0 : (t.lat >= TO) ? TO : t.lat + 1;
        if (!t.exp_err && !t.wr) model_rdata = t.prdata;
        t.exp_rdata = model_rdata;
        prio_m = ~t.req;
        return t;
    endfunction

    task automatic do_round(input bit v0, input bit v1, input txn_t a, input txn_t b);
        txn_t ord[2];
        int n;
        int cyc;
        int exp_first;
        bit got_first;
        a.req = 1'b0;
        b.req = 1'b1;
        if (v0 && v1) begin
            n = 2;
            if (prio_m) begin ord[0] = b; ord[1] = a; end
            else        begin ord[0] = a; ord[1] = b; end
        end else begin
            n = 1;
            ord[0] = v1 ? b : a;
            ord[1] = a;
        end
        for (int i = 0; i < n; i++) begin
            ord[i] = predict(ord[i]);
            exp_q.push_back(ord[i]);
        end
        req0_write = a.wr; req0_sel = a.sel; req0_addr = a.addr; req0_wdata = a.wdata;
        req1_write = b.wr; req1_sel = b.sel; req1_addr = b.addr; req1_wdata = b.wdata;
        exp_first = ((done != 2'b00) ? 1 : 0) + (ord[0].legal ? int'(ord[0].exp_acc) + 2 : 1);
        req0_valid = v0;
        req1_valid = v1;
        cyc = 0;
        got_first = 1'b0;
        while ((req0_valid || req1_valid) && cyc < 300) begin
            @(negedge pclk);
            cyc++;
            if (done != 2'b00 && !got_first) begin
                got_first = 1'b1;
                chk("latency", cyc, exp_first);
            end
            if (done[0]) req0_valid = 1'b0;
            if (done[1]) req1_valid = 1'b0;
        end
        if (req0_valid || req1_valid) begin
            checks++;
            failures++;
            $display("FAIL round_timeout: valid=%b%b still pending after %0d cycles, required done",
                     req1_valid, req0_valid, cyc);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    // Slave model: pready stays low for the queued transaction's latency.
    initial begin
        int unsigned acnt;
        acnt = 0;
        pready = 1'b0;
        prdata = '0;
        forever begin
            @(negedge pclk);
            if (penable && exp_q.size() > 0) begin
                acnt++;
                pready = (acnt > exp_q[0].lat);
                prdata = exp_q[0].prdata;
            end else begin
                acnt = 0;
                pready = ($urandom_range(0, 1) == 1);
                prdata = $urandom;
            end
        end
    end

    // Monitor: tracks bus phases and scores each done pulse against the queue.
    initial begin
        int setup_seen, access_seen;
        bit held_bad;
        logic [1:0] cap_sel;
        logic cap_wr;
        logic [4:0] cap_addr;
        logic [31:0] cap_wdata;
        txn_t t;
        setup_seen = 0; access_seen = 0; held_bad = 1'b0;
        cap_sel = '0; cap_wr = 1'b0; cap_addr = '0; cap_wdata = '0;
        forever begin
            @(negedge pclk);
            if (!Reset) begin
                setup_seen = 0; access_seen = 0; held_bad = 1'b0;
            end else begin
                chk("busy_vs_psel", 32'(busy), 32'(psel != 2'b00));
                if (done == 2'b00) chk("err_without_done", 32'(err), 0);
                if (psel != 2'b00 && !penable) begin
                    setup_seen++;
                    cap_sel = psel; cap_wr = pwrite; cap_addr = paddr; cap_wdata = pwdata;
                end
                if (penable) begin
                    access_seen++;
                    if ({psel, pwrite, paddr, pwdata} !== {cap_sel, cap_wr, cap_addr, cap_wdata})
                        held_bad = 1'b1;
                end
                if (done != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: got done=%b, required no completion", done);
                    end else begin
                        t = exp_q.pop_front();
                        chk("done_onehot", 32'(done), t.req ? 2 : 1);
                        chk("err", 32'(err), 32'(t.exp_err));
                        chk("rdata", rdata, t.exp_rdata);
                        chk("setup_cycles", setup_seen, t.legal ? 1 : 0);
                        chk("access_cycles", access_seen, t.exp_acc);
                        if (t.legal) begin
                            chk("psel", 32'(cap_sel), 32'(t.sel));
                            chk("pwrite", 32'(cap_wr), 32'(t.wr));
                            chk("paddr", 32'(cap_addr), 32'(t.addr));
                            chk("pwdata", cap_wdata, t.wdata);
                            chk("held_fields", 32'(held_bad), 0);
                        end
                    end
                    setup_seen = 0; access_seen = 0; held_bad = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        int wait_cyc;
        Reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_write = 1'b0; req1_write = 1'b0;
        req0_sel = '0; req1_sel = '0; req0_addr = '0; req1_addr = '0;
        req0_wdata = '0; req1_wdata = '0;
        repeat (3) @(negedge pclk);
        chk_all_zero("reset");
        Reset = 1'b1;
        repeat (2) @(negedge pclk);

        // Directed cases.
        do_round(1, 0, mk(1, 2'b01, 5'd1, 32'hABCD1234, 32'h0, 0), mk(0, 2'b01, 0, 0, 0, 0));
        do_round(0, 1, mk(0, 2'b01, 0, 0, 0, 0), mk(0, 2'b10, 5'd2, 32'h0, 32'h00000AAA, 3));
        do_round(1, 1, mk(1, 2'b01, 5'd3, 32'h11111111, 32'h0, 1), mk(0, 2'b10, 5'd4, 32'h0, 32'h22222222, 0));
        do_round(1, 1, mk(0, 2'b10, 5'd5, 32'h0, 32'h33333333, 2), mk(1, 2'b01, 5'd6, 32'h44444444, 32'h0, 0));
        do_round(1, 0, mk(1, 2'b11, 5'd7, 32'h55555555, 32'h0, 0), mk(0, 2'b01, 0, 0, 0, 0));
        do_round(1, 0, mk(0, 2'b01, 5'd8, 32'h0, 32'hDEADBEEF, 99), mk(0, 2'b01, 0, 0, 0, 0));
        do_round(0, 1, mk(0, 2'b01, 0, 0, 0, 0), mk(0, 2'b10, 5'd9, 32'h0, 32'h0BADF00D, TO - 1));
        do_round(1, 1, mk(0, 2'b00, 5'd10, 32'h0, 32'h0, 0), mk(1, 2'b10, 5'd11, 32'h66666666, 32'h0, 1));

        // Randomized rounds.
        for (int r = 0; r < 60; r++) begin
            int unsigned m;
            m = $urandom_range(1, 3);
            do_round(m[0], m[1], rnd_txn(), rnd_txn());
            repeat ($urandom_range(0, 2)) @(negedge pclk);
        end

        // Reset in ACCESS aborts silently; the next tie goes to requester 0.
        repeat (2) @(negedge pclk);
        t = mk(1, 2'b01, 5'd12, 32'hCAFEF00D, 32'h0, 99);
        exp_q.push_back(t);
        req0_write = t.wr; req0_sel = t.sel; req0_addr = t.addr; req0_wdata = t.wdata;
        req0_valid = 1'b1;
        wait_cyc = 0;
        while (!penable && wait_cyc < 10) begin
            @(negedge pclk);
            wait_cyc++;
        end
        chk("reach_access", 32'(penable), 1);
        repeat (2) @(negedge pclk);
        Reset = 1'b0;
        req0_valid = 1'b0;
        @(negedge pclk);
        chk_all_zero("rst_access");
        exp_q.delete();
        prio_m = 1'b0;
        model_rdata = 32'h0;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("no_done_after_reset", 32'(done), 0);
        end
        do_round(1, 1, mk(0, 2'b10, 5'd13, 32'h0, 32'h77777777, 0), mk(1, 2'b01, 5'd14, 32'h88888888, 32'h0, 0));
        repeat (3) @(negedge pclk);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
